// File: rtl/ysyx_22050039_mem_pkg.sv
// Shared types and helpers for the data-memory responder.
// The address range test lives here so that any other memory-side block can reuse it.
package ysyx_22050039_mem_pkg;
  localparam int          XLEN_DFLT = 64;
  localparam int          MASK_W    = XLEN_DFLT / 8;
  localparam logic [63:0] BASE_DFLT = 64'h8000_0000;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  // Check the lower bound before subtracting, so that an address below base
  // cannot wrap around into the window.
  function automatic logic in_range(input logic [63:0] addr, input logic [63:0] base,
                                    input int unsigned addr_w);
    logic [63:0] span;
    span = 64'd8 << addr_w;
    return (addr >= base) && ((addr - base) < span);
  endfunction
endpackage

// File: rtl/ysyx_22050039_dmem_resp_if.sv
// Request/response channel between the LSU (master) and the data-memory responder (slave).
interface ysyx_22050039_dmem_resp_if
  import ysyx_22050039_mem_pkg::*;
#(
  parameter int XLEN = XLEN_DFLT,
  parameter int MW   = XLEN / 8
);
  logic            req_valid;
  logic            req_ready;
  logic            req_wen;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [MW-1:0]   req_wmask;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/ysyx_22050039_dmem_array.sv
// Doubleword storage with a synchronous byte-masked write port and a combinational read port.
// Contents are never reset.
module ysyx_22050039_dmem_array
  import ysyx_22050039_mem_pkg::*;
#(
  parameter int XLEN   = XLEN_DFLT,
  parameter int ADDR_W = 10,
  parameter int MW     = MASK_W
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_widx,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic [MW-1:0]     i_wmask,
  input  logic [ADDR_W-1:0] i_ridx,
  output logic [XLEN-1:0]   o_rdata
);
  logic [XLEN-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < MW; b++) begin
        if (i_wmask[b]) r_mem[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_ridx];
endmodule

// File: rtl/ysyx_22050039_dmem_resp.sv
// Data-memory responder: one load/store in flight, fixed latency LAT from accept to response,
// response held until the requester takes it.
module ysyx_22050039_dmem_resp
  import ysyx_22050039_mem_pkg::*;
#(
  parameter int              XLEN   = XLEN_DFLT,
  parameter int              ADDR_W = 10,
  parameter logic [XLEN-1:0] BASE   = BASE_DFLT,
  parameter int              LAT    = 2
) (
  input logic                     clk,
  input logic                     rst,
  ysyx_22050039_dmem_resp_if.slave bus
);
  localparam int MW = XLEN / 8;

  state_e            r_state, w_next;
  logic [3:0]        r_cnt;
  logic              r_wen;
  logic [XLEN-1:0]   r_addr, r_wdata;
  logic [MW-1:0]     r_wmask;
  logic [XLEN-1:0]   r_rdata;
  logic              r_err;

  logic              w_accept, w_last_wait, w_commit;
  logic              w_c_wen, w_inr;
  logic [XLEN-1:0]   w_c_addr, w_c_wdata, w_arr_rdata;
  logic [MW-1:0]     w_c_wmask;
  logic [ADDR_W-1:0] w_idx;

  assign w_accept    = bus.req_valid & bus.req_ready;
  assign w_last_wait = (r_state == WAIT) && (r_cnt == 4'(LAT - 1));
  // Commit on the edge that enters RESP; a reset on that edge aborts it.
  assign w_commit    = !rst && (((r_state == IDLE) && w_accept && (LAT == 1)) || w_last_wait);

  // With LAT == 1 the commit edge is the accept edge, so take the live request.
  always_comb begin
    if (r_state == IDLE) begin
      w_c_wen   = bus.req_wen;
      w_c_addr  = bus.req_addr;
      w_c_wdata = bus.req_wdata;
      w_c_wmask = bus.req_wmask;
    end else begin
      w_c_wen   = r_wen;
      w_c_addr  = r_addr;
      w_c_wdata = r_wdata;
      w_c_wmask = r_wmask;
    end
  end

  assign w_inr = in_range(64'(w_c_addr), 64'(BASE), ADDR_W);
  assign w_idx = ADDR_W'((w_c_addr - BASE) >> 3);

  ysyx_22050039_dmem_array #(.XLEN(XLEN), .ADDR_W(ADDR_W), .MW(MW)) u_array (
    .clk     (clk),
    .i_we    (w_commit & w_inr & w_c_wen),
    .i_widx  (w_idx),
    .i_wdata (w_c_wdata),
    .i_wmask (w_c_wmask),
    .i_ridx  (w_idx),
    .o_rdata (w_arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = (LAT > 1) ? WAIT : RESP;
      WAIT:    if (w_last_wait) w_next = RESP;
      RESP:    if (bus.resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (r_state == IDLE) && !rst;
    bus.resp_valid = (r_state == RESP);
    bus.resp_rdata = r_rdata;
    bus.resp_err   = r_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == IDLE && w_accept) r_cnt <= 4'd1;
      else if (r_state == WAIT)        r_cnt <= r_cnt + 4'd1;
      else                             r_cnt <= '0;
      if (w_commit) begin
        r_rdata <= (w_inr && !w_c_wen) ? w_arr_rdata : '0;
        r_err   <= !w_inr;
      end
    end
  end

  // Request fields are only captured on a completed handshake.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_wen   <= bus.req_wen;
      r_addr  <= bus.req_addr;
      r_wdata <= bus.req_wdata;
      r_wmask <= bus.req_wmask;
    end
  end
endmodule

// File: doc/ysyx_22050039_dmem_resp.md
Name: ysyx_22050039_dmem_resp

Overview:
- Data-memory responder: the memory-side end of the load/store path that the execute stage drives.
- Accepts one load or store request at a time over a valid/ready handshake.
- Applies byte-masked writes to an internal doubleword array.
- Returns read data (or an error) after a fixed, parameterised latency over a second valid/ready handshake.
- Replaces direct DPI memory calls when the core moves to a bus-based LSU.

Parameters:
- XLEN, 64, data and address width.
- ADDR_W, 10, doubleword index bits (1024 x 64-bit = 8 KiB).
- BASE, 64'h8000_0000, byte address of array entry 0.
- LAT, 2, cycles from request acceptance to resp_valid; legal range 1..15.

Ports:
- clk  in  1  single clock, all state on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE with rst low.
- req_wen  in  1  1 = store, 0 = load.
- req_addr  in  XLEN  byte address; bits [2:0] ignored for indexing.
- req_wdata  in  XLEN  store data, doubleword-lane aligned.
- req_wmask  in  8  byte-enable per lane; bit i covers wdata[8i+7:8i].
- resp_valid  out  1  response present.
- resp_ready  in  1  requester accepts response.
- resp_rdata  out  XLEN  full aligned doubleword for loads; 0 for stores and errors.
- resp_err  out  1  address outside [BASE, BASE + 8*2^ADDR_W).

Behaviour:
- Reset (rst high at posedge):
  - state = IDLE, resp_valid = 0, resp_rdata = 0, resp_err = 0, latency counter = 0.
  - req_ready is held 0 while rst is high.
  - Array contents are not reset.
- FSM states:
  - IDLE: req_ready = 1. On req_valid & req_ready, latch wen/addr/wdata/wmask. Go to WAIT if LAT > 1, otherwise to RESP.
  - WAIT: counter counts up from 1. When it reaches LAT-1, the commit happens on that edge and the FSM enters RESP. req_ready = 0.
  - RESP: resp_valid = 1, and rdata/err are held stable. On resp_ready, go to IDLE with resp_valid = 0. req_ready = 0.
- Latency:
  - Request accepted at edge N gives resp_valid high after edge N+LAT.
  - Back-to-back throughput is one transaction per LAT+2 cycles minimum: IDLE re-entry costs one cycle. No request is accepted in the same cycle a response is consumed.
- Commit, on the edge entering RESP:
  - Index = (addr - BASE) >> 3, truncated to ADDR_W bits.
  - In range, store: for each set mask bit, write that byte lane. resp_rdata = 0, resp_err = 0. A mask of 8'h00 is a legal no-op store.
  - In range, load: resp_rdata = array[index] captured after any prior writes. resp_err = 0.
  - Out of range (addr < BASE, or addr >= BASE + 8*2^ADDR_W): no array write, resp_rdata = 0, resp_err = 1.
  - Address arithmetic is unsigned, full XLEN. Wrap-around of addr - BASE must not alias into range, so compare before subtracting.
- Misaligned sub-doubleword accesses are the requester's job: it supplies the lane-shifted mask and data and extracts bytes from the full doubleword. The responder does no shifting.
- Backpressure: resp_valid stays high and the outputs stay frozen for any number of cycles while resp_ready = 0. Inputs on the req_* ports are ignored outside IDLE.
- Reset mid-transaction:
  - An aborted store that has not yet reached commit leaves the array unchanged.
  - A store already committed stays written.
  - Any pending response is dropped.
- req_valid may drop without acceptance. No request state is latched unless the handshake completes.

Decomposition:
- Shared package ysyx_22050039_mem_pkg:
  - state enum {IDLE, WAIT, RESP}.
  - MASK_W = XLEN/8.
  - Default BASE constant.
  - Helper function for the in-range test.
- Sub-module ysyx_22050039_dmem_array:
  - 2^ADDR_W x XLEN storage.
  - Synchronous byte-masked write port and combinational read port, indexed by ADDR_W bits.
  - The FSM/handshake wrapper owns all control; the array has no reset.

Test Plan:
- Reset then idle: hold rst 3 cycles with req_valid=1 -> req_ready=0, resp_valid=0. After release, req_ready=1 next cycle with no spurious response.
- Full store/load, LAT=2: store addr 8000_0010, wdata 1122334455667788, mask FF -> resp_valid 2 cycles after accept, rdata 0, err 0. Load same addr -> rdata 1122334455667788.
- Byte-masked partial store: after the above, store addr 8000_0010, wdata 00000000AABB0000, mask 8'h0C -> load returns 11223344AABB7788. Mask 00 store leaves the value unchanged.
- Out of range: load 7FFF_FFF8, load 8000_2000, store FFFF_FFFF_FFFF_FFF8 -> each gives err=1, rdata 0. A subsequent load of 8000_0000 shows no corruption.
- Backpressure and back-to-back: resp_ready=0 for 5 cycles -> resp_valid and rdata stable, req_ready=0 throughout. Then release and immediately present the next request -> accepted exactly one cycle after the handshake. Repeat with LAT=1 and LAT=15.
- Reset mid-operation: accept store to 8000_0018 (old value 0), assert rst in the WAIT cycle -> array[3] still 0 and no resp_valid after reset.
